imm_gen: RTL and testbench
==========================

Name: imm_gen

Overview:
- Registered immediate generator for the 64-bit RISC-V datapath.
- Takes a 12-bit immediate field from decode and produces a 64-bit operand for the ALU/branch unit.
- Supports four extension formats: sign-extend, zero-extend, branch offset (sign-extend, shift left 1) and upper (sign-extend, shift left 12).
- One-cycle latency with a valid flag; sits between instruction decode and the execute-stage operand mux.

Parameters:
- IN_W, 12, width of the immediate input field (minimum 2).
- OUT_W, 64, width of the extended output (must be ≥ IN_W+12).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- imm_in  input  IN_W  raw immediate field; bit IN_W-1 is the sign bit.
- fmt  input  2  format select: 0=SEXT, 1=ZEXT, 2=BRANCH, 3=UPPER.
- in_valid  input  1  imm_in/fmt are valid this cycle.
- imm_out  output  OUT_W  extended immediate (registered).
- out_valid  output  1  imm_out holds a result captured on the previous valid cycle.

Behaviour:
- Single clock domain. clk is the only clock. reset is synchronous and active-high.
- Reset: on a rising edge with reset=1, imm_out <= 0 and out_valid <= 0. Reset wins over in_valid in the same cycle.
- Latency: exactly 1 cycle. A rising edge with in_valid=1 and reset=0 loads imm_out with the result for the current imm_in/fmt and sets out_valid=1.
- in_valid=0 (reset=0): imm_out holds its previous value; out_valid <= 0.
- Back-to-back valid inputs produce back-to-back results, one per cycle. No stall or backpressure.
- Result per fmt, with S = imm_in[IN_W-1]:
  - fmt=0 SEXT: bits [IN_W-1:0] = imm_in; bits above = S.
  - fmt=1 ZEXT: bits [IN_W-1:0] = imm_in; bits above = 0.
  - fmt=2 BRANCH: the SEXT value shifted left by 1; bit 0 = 0; MSB bits beyond OUT_W discarded.
  - fmt=3 UPPER: the SEXT value shifted left by 12; bits [11:0] = 0.
- Arithmetic: pure bit manipulation. No overflow detection; shifted-out bits are dropped.
- X/Z on imm_in or fmt when in_valid=0 must not disturb imm_out.
- No internal state other than the output registers.

Optional Feature:
- Macro: IMM_GEN_STATUS_EN.
- Defined: adds outputs is_neg (1 bit) and is_zero (1 bit), registered alongside imm_out with the same timing.
  - is_neg = imm_out[OUT_W-1] of the new result.
  - is_zero = (new result == 0).
  - Both reset to 0; both hold when in_valid=0.
- Not defined: these ports and their registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, imm_in=12'hFFF -> imm_out=0, out_valid=0 throughout; is_neg=0 and is_zero=0 if IMM_GEN_STATUS_EN is defined.
- SEXT sequence, fmt=0, in_valid=1, one value per cycle: imm_in=12'h795, 12'hB95, 12'hA95, 12'h395 -> next-cycle imm_out = 64'h0000000000000795, 64'hFFFFFFFFFFFFFB95, 64'hFFFFFFFFFFFFFA95, 64'h0000000000000395; out_valid=1 each cycle.
- ZEXT/BRANCH:
  - fmt=1, imm_in=12'hB95 -> 64'h0000000000000B95.
  - fmt=2, imm_in=12'hB95 -> 64'hFFFFFFFFFFFFF72A.
  - fmt=2, imm_in=12'h795 -> 64'h0000000000000F2A.
- UPPER:
  - fmt=3, imm_in=12'h795 -> 64'h0000000000795000.
  - fmt=3, imm_in=12'hB95 -> 64'hFFFFFFFFFFB95000.
- Hold and reset priority:
  - Load 12'h795 (fmt=0), then drop in_valid and change imm_in to 12'h000 -> imm_out stays 64'h795, out_valid=0.
  - Then reset=1 with in_valid=1 -> imm_out=0, out_valid=0.
- Boundaries:
  - fmt=0, imm_in=12'h800 -> 64'hFFFFFFFFFFFFF800 (is_neg=1).
  - fmt=0, imm_in=12'h7FF -> 64'h00000000000007FF.
  - fmt=0, imm_in=12'h000 -> 0 (is_zero=1 when IMM_GEN_STATUS_EN is defined).

Source files
------------

// File: rtl/imm_gen.sv
// Registered 64-bit immediate generator: SEXT/ZEXT/BRANCH/UPPER formats, 1-cycle latency.
// Optional IMM_GEN_STATUS_EN adds registered is_neg/is_zero flags.
module imm_gen #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  imm_in,
  input  logic [1:0]       fmt,
  input  logic             in_valid,
`ifdef IMM_GEN_STATUS_EN
  output logic             is_neg,
  output logic             is_zero,
`endif
  output logic [OUT_W-1:0] imm_out,
  output logic             out_valid
);

  localparam logic [1:0] FMT_SEXT   = 2'd0;
  localparam logic [1:0] FMT_ZEXT   = 2'd1;
  localparam logic [1:0] FMT_BRANCH = 2'd2;
  localparam logic [1:0] FMT_UPPER  = 2'd3;

  logic             sign;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] branch;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] nxt;

  logic is_sext;
  logic is_zext;
  logic is_branch;
  logic is_upper;

  assign sign   = imm_in[IN_W-1];
  assign sext   = {{(OUT_W-IN_W){sign}}, imm_in};
  assign zext   = {{(OUT_W-IN_W){1'b0}}, imm_in};
  assign branch = {sext[OUT_W-2:0], 1'b0};
  assign upper  = {sext[OUT_W-13:0], 12'b0};

  assign is_sext   = (fmt == FMT_SEXT);
  assign is_zext   = (fmt == FMT_ZEXT);
  assign is_branch = (fmt == FMT_BRANCH);
  assign is_upper  = (fmt == FMT_UPPER);

  always_comb begin
    nxt = '0;
    unique case (1'b1)
      is_sext:   nxt = sext;
      is_zext:   nxt = zext;
      is_branch: nxt = branch;
      is_upper:  nxt = upper;
      default:   nxt = '0;
    endcase
  end

  // Data only loads on valid, so garbage on idle inputs never reaches imm_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_out   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        imm_out <= nxt;
      end
    end
  end

`ifdef IMM_GEN_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      is_neg  <= 1'b0;
      is_zero <= 1'b0;
    end else if (in_valid) begin
      is_neg  <= nxt[OUT_W-1];
      is_zero <= (nxt == '0);
    end
  end
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed plan vectors plus
// randomized traffic against an arithmetic reference model.
module tb_imm_gen;

  logic        clk;
  logic        reset;
  logic [11:0] imm_in;
  logic [1:0]  fmt;
  logic        in_valid;
  logic [63:0] imm_out;
  logic        out_valid;
`ifdef IMM_GEN_STATUS_EN
  logic        is_neg;
  logic        is_zero;
`endif

  int n_checks;
  int n_fail;

  logic [63:0] e_out;
  logic        e_valid;
  logic        e_neg;
  logic        e_zero;

  imm_gen #(
    .IN_W(12),
    .OUT_W(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .imm_in(imm_in),
    .fmt(fmt),
    .in_valid(in_valid),
`ifdef IMM_GEN_STATUS_EN
    .is_neg(is_neg),
    .is_zero(is_zero),
`endif
    .imm_out(imm_out),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: treat the field as a signed integer, then scale.
  function automatic logic [63:0] ref_imm(input logic [11:0] i,
                                          input logic [1:0] f);
    longint s;
    s = longint'(i);
    if (i >= 12'h800) s = s - 4096;
    case (f)
      2'd0:    return s;
      2'd1:    return longint'(i);
      2'd2:    return s * 2;
      default: return s * 4096;
    endcase
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [11:0] i, input logic [1:0] f);
    @(negedge clk);
    reset    = r;
    in_valid = v;
    imm_in   = i;
    fmt      = f;
    @(posedge clk);
    #1;
    if (r) begin
      e_out = '0; e_valid = 1'b0; e_neg = 1'b0; e_zero = 1'b0;
    end else begin
      e_valid = v;
      if (v) begin
        e_out  = ref_imm(i, f);
        e_neg  = e_out[63];
        e_zero = (e_out == 64'd0);
      end
    end
    chk("model_out", imm_out, e_out);
    chk("model_valid", {63'd0, out_valid}, {63'd0, e_valid});
`ifdef IMM_GEN_STATUS_EN
    chk("model_neg", {63'd0, is_neg}, {63'd0, e_neg});
    chk("model_zero", {63'd0, is_zero}, {63'd0, e_zero});
`endif
  endtask

  typedef struct {
    logic [1:0]  f;
    logic [11:0] i;
    logic [63:0] x;
  } vec_t;

  vec_t plan[$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    e_out = '0; e_valid = 1'b0; e_neg = 1'b0; e_zero = 1'b0;
    reset = 1'b1; in_valid = 1'b1; imm_in = 12'hFFF; fmt = 2'd0;

    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 12'hFFF, 2'd0);
      chk("reset_out", imm_out, 64'd0);
      chk("reset_valid", {63'd0, out_valid}, 64'd0);
`ifdef IMM_GEN_STATUS_EN
      chk("reset_neg", {63'd0, is_neg}, 64'd0);
      chk("reset_zero", {63'd0, is_zero}, 64'd0);
`endif
    end

    plan.push_back('{2'd0, 12'h795, 64'h0000000000000795});
    plan.push_back('{2'd0, 12'hB95, 64'hFFFFFFFFFFFFFB95});
    plan.push_back('{2'd0, 12'hA95, 64'hFFFFFFFFFFFFFA95});
    plan.push_back('{2'd0, 12'h395, 64'h0000000000000395});
    plan.push_back('{2'd1, 12'hB95, 64'h0000000000000B95});
    plan.push_back('{2'd2, 12'hB95, 64'hFFFFFFFFFFFFF72A});
    plan.push_back('{2'd2, 12'h795, 64'h0000000000000F2A});
    plan.push_back('{2'd3, 12'h795, 64'h0000000000795000});
    plan.push_back('{2'd3, 12'hB95, 64'hFFFFFFFFFFB95000});
    plan.push_back('{2'd0, 12'h800, 64'hFFFFFFFFFFFFF800});
    plan.push_back('{2'd0, 12'h7FF, 64'h00000000000007FF});
    plan.push_back('{2'd0, 12'h000, 64'h0000000000000000});

    foreach (plan[k]) begin
      step(1'b0, 1'b1, plan[k].i, plan[k].f);
      chk($sformatf("plan%0d_out", k), imm_out, plan[k].x);
      chk($sformatf("plan%0d_valid", k), {63'd0, out_valid}, 64'd1);
    end
`ifdef IMM_GEN_STATUS_EN
    chk("zero_flag", {63'd0, is_zero}, 64'd1);
    step(1'b0, 1'b1, 12'h800, 2'd0);
    chk("neg_flag", {63'd0, is_neg}, 64'd1);
`endif

    step(1'b0, 1'b1, 12'h795, 2'd0);
    step(1'b0, 1'b0, 12'h000, 2'd0);
    chk("hold_out", imm_out, 64'h795);
    chk("hold_valid", {63'd0, out_valid}, 64'd0);
    step(1'b1, 1'b1, 12'h795, 2'd0);
    chk("prio_out", imm_out, 64'd0);
    chk("prio_valid", {63'd0, out_valid}, 64'd0);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           12'($urandom), 2'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
